// File: rtl/alu_ctrl_exec.sv
// ALU control decode + execute with valid/ready handshake and optional serial shifter.
module alu_ctrl_exec #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned SERIAL_SHIFT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [3:0]      alu_ctrl,
    output logic            illegal,
    output logic            busy
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_XOR  = 4'b0011;
    localparam logic [3:0] C_SLL  = 4'b0100;
    localparam logic [3:0] C_SRL  = 4'b0101;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_SLTU = 4'b1000;
    localparam logic [3:0] C_SRA  = 4'b1001;
    localparam logic [3:0] C_ILL  = 4'b1111;

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    state_t              state, state_n;
    logic                out_valid_n, zero_n, illegal_n;
    logic [XLEN-1:0]     result_n, work, work_n;
    logic [3:0]          alu_ctrl_n;
    logic [SHAMT_W-1:0]  cnt, cnt_n;

    logic [3:0]          dec_c;
    logic [XLEN-1:0]     exec_c, step_c;
    logic [SHAMT_W-1:0]  shamt_c;
    logic                f7_zero_c, f7_alt_c, is_r_c, is_shift_c, accept_c, consume_c;

    assign shamt_c    = op_b[SHAMT_W-1:0];
    assign f7_zero_c  = (funct7 == 7'b0000000);
    assign f7_alt_c   = (funct7 == 7'b0100000);
    assign is_r_c     = (alu_op == 2'b10);
    assign in_ready   = (state == IDLE) && (!out_valid || out_ready);
    assign busy       = (state != IDLE);
    assign accept_c   = in_valid && in_ready;
    assign consume_c  = out_valid && out_ready;
    assign is_shift_c = (dec_c == C_SLL) || (dec_c == C_SRL) || (dec_c == C_SRA);

    // Decode alu_op/funct fields into a control code (1111 = undefined encoding)
    always_comb begin
        dec_c = C_ILL;
        case (alu_op)
            2'b00: dec_c = C_ADD;
            2'b01: dec_c = C_SUB;
            default: begin
                case (funct3)
                    3'b000: begin
                        if (!is_r_c || f7_zero_c) dec_c = C_ADD;
                        else if (f7_alt_c)        dec_c = C_SUB;
                    end
                    3'b001: if (f7_zero_c)             dec_c = C_SLL;
                    3'b010: if (!is_r_c || f7_zero_c)  dec_c = C_SLT;
                    3'b011: if (!is_r_c || f7_zero_c)  dec_c = C_SLTU;
                    3'b100: if (!is_r_c || f7_zero_c)  dec_c = C_XOR;
                    3'b101: begin
                        if (f7_zero_c)     dec_c = C_SRL;
                        else if (f7_alt_c) dec_c = C_SRA;
                    end
                    3'b110: if (!is_r_c || f7_zero_c)  dec_c = C_OR;
                    3'b111: if (!is_r_c || f7_zero_c)  dec_c = C_AND;
                    default: dec_c = C_ILL;
                endcase
            end
        endcase
    end

    // Single-cycle execute of the decoded op (barrel shifter for the non-serial path)
    always_comb begin
        exec_c = '0;
        case (dec_c)
            C_AND:  exec_c = op_a & op_b;
            C_OR:   exec_c = op_a | op_b;
            C_ADD:  exec_c = op_a + op_b;
            C_XOR:  exec_c = op_a ^ op_b;
            C_SUB:  exec_c = op_a - op_b;
            C_SLT:  exec_c = XLEN'($signed(op_a) < $signed(op_b));
            C_SLTU: exec_c = XLEN'(op_a < op_b);
            C_SLL:  exec_c = op_a << shamt_c;
            C_SRL:  exec_c = op_a >> shamt_c;
            C_SRA:  exec_c = XLEN'($signed(op_a) >>> shamt_c);
            default: exec_c = '0;
        endcase
    end

    // One-bit shift step of the working register for the serial shifter
    always_comb begin
        case (alu_ctrl)
            C_SLL:   step_c = {work[XLEN-2:0], 1'b0};
            C_SRL:   step_c = {1'b0, work[XLEN-1:1]};
            default: step_c = {work[XLEN-1], work[XLEN-1:1]};
        endcase
    end

    // Next-state and output-register logic
    always_comb begin
        state_n     = state;
        out_valid_n = out_valid;
        result_n    = result;
        zero_n      = zero;
        alu_ctrl_n  = alu_ctrl;
        illegal_n   = illegal;
        work_n      = work;
        cnt_n       = cnt;

        if (consume_c) out_valid_n = 1'b0;

        case (state)
            IDLE: begin
                if (accept_c) begin
                    alu_ctrl_n = dec_c;
                    illegal_n  = (dec_c == C_ILL);
                    if ((SERIAL_SHIFT != 0) && is_shift_c && (shamt_c != '0)) begin
                        state_n = SHIFT;
                        work_n  = op_a;
                        cnt_n   = shamt_c;
                    end else begin
                        result_n    = exec_c;
                        zero_n      = (exec_c == '0);
                        out_valid_n = 1'b1;
                    end
                end
            end
            SHIFT: begin
                work_n = step_c;
                cnt_n  = cnt - SHAMT_W'(1);
                if (cnt == SHAMT_W'(1)) begin
                    result_n    = step_c;
                    zero_n      = (step_c == '0);
                    out_valid_n = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            alu_ctrl  <= '0;
            illegal   <= 1'b0;
            work      <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            out_valid <= out_valid_n;
            result    <= result_n;
            zero      <= zero_n;
            alu_ctrl  <= alu_ctrl_n;
            illegal   <= illegal_n;
            work      <= work_n;
            cnt       <= cnt_n;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Scoreboard bench for alu_ctrl_exec (XLEN=32, serial shifter).
module tb_alu_ctrl_exec;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  alu_op;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b, result;
    logic        zero, illegal, busy;
    logic [3:0]  alu_ctrl;

    alu_ctrl_exec #(.XLEN(32), .SERIAL_SHIFT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct7(funct7), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .alu_ctrl(alu_ctrl), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic [3:0]  ctrl;
        logic        ill;
        int          lat;
        longint      t_acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, req, $time);
    endtask

    // Drive one request, wait for acceptance, and optionally queue its expected response
    task automatic issue(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [3:0] ec, input int elat,
                         input bit push);
        exp_t e;
        int   n;
        in_valid = 1'b1; alu_op = op; funct7 = f7; funct3 = f3; op_a = a; op_b = b;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        e.res = er; e.z = (er == 32'd0); e.ctrl = ec; e.ill = (ec == 4'hF);
        e.lat = elat; e.t_acc = longint'($time);
        if (push) exp_q.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every consumed result against the head of the scoreboard
    initial begin
        exp_t e;
        int   lat;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result",   64'(result),   64'(e.res));
                    chk("zero",     64'(zero),     64'(e.z));
                    chk("alu_ctrl", 64'(alu_ctrl), 64'(e.ctrl));
                    chk("illegal",  64'(illegal),  64'(e.ill));
                    if (e.lat != 0) begin
                        lat = int'((longint'($time) - e.t_acc + 5) / 10);
                        chk("latency", 64'(lat), 64'(e.lat));
                    end
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        int bcnt;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = '0; funct7 = '0; funct3 = '0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result",    64'(result),    64'd0);
        chk("rst_zero",      64'(zero),      64'd0);
        chk("rst_alu_ctrl",  64'(alu_ctrl),  64'd0);
        chk("rst_illegal",   64'(illegal),   64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk); #1;

        // Basic decode/execute, back-to-back
        issue(2'b10, 7'h00, 3'b000, 32'd5, 32'd7, 32'd12, 4'b0010, 1, 1'b1);
        issue(2'b01, 7'h55, 3'b111, 32'h1234, 32'h1234, 32'd0, 4'b0110, 1, 1'b1);

        // Serial SRA by 4: busy for 4 cycles, result 5 cycles after accept
        issue(2'b10, 7'h20, 3'b101, 32'h8000_0000, 32'd4, 32'hF800_0000, 4'b1001, 5, 1'b1);
        bcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
        chk("busy_cycles", 64'(bcnt), 64'd4);
        @(posedge clk); #1;

        issue(2'b10, 7'h00, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0111, 1, 1'b1);
        issue(2'b10, 7'h00, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b1000, 1, 1'b1);
        issue(2'b10, 7'h01, 3'b000, 32'd9, 32'd9, 32'd0, 4'b1111, 1, 1'b1);
        issue(2'b11, 7'h20, 3'b000, 32'd3, 32'd1, 32'd4, 4'b0010, 1, 1'b1);
        issue(2'b10, 7'h00, 3'b100, 32'hF0F0, 32'hFF00, 32'h0FF0, 4'b0011, 1, 1'b1);
        issue(2'b10, 7'h00, 3'b110, 32'hF0F0, 32'hFF00, 32'hFFF0, 4'b0001, 1, 1'b1);
        issue(2'b10, 7'h00, 3'b111, 32'hF0F0, 32'hFF00, 32'hF000, 4'b0000, 1, 1'b1);
        issue(2'b11, 7'h20, 3'b001, 32'd1, 32'd1, 32'd0, 4'b1111, 1, 1'b1);
        issue(2'b11, 7'h00, 3'b101, 32'h8000_0000, 32'h24, 32'h0800_0000, 4'b0101, 5, 1'b1);
        issue(2'b10, 7'h00, 3'b001, 32'hABCD, 32'h20, 32'hABCD, 4'b0100, 1, 1'b1);
        issue(2'b10, 7'h00, 3'b001, 32'd1, 32'd31, 32'h8000_0000, 4'b0100, 32, 1'b1);
        drain();

        // Backpressure: hold result, ignore request while not ready
        out_ready = 1'b0;
        issue(2'b00, 7'h00, 3'b000, 32'd2, 32'd2, 32'd4, 4'b0010, 0, 1'b1);
        in_valid = 1'b1; alu_op = 2'b00; op_a = 32'd9; op_b = 32'd9;
        repeat (3) begin
            @(negedge clk);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_result",    64'(result),    64'd4);
            chk("hold_in_ready",  64'(in_ready),  64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(2'b00, 7'h00, 3'b000, 32'd1, 32'd1, 32'd2, 4'b0010, 1, 1'b1);
        @(negedge clk);
        chk("b2b_out_valid", 64'(out_valid), 64'd1);
        drain();

        // Reset in the 10th cycle of a 31-bit serial shift
        issue(2'b10, 7'h00, 3'b001, 32'd1, 32'd31, 32'd0, 4'b0100, 0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        chk("mid_shift_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("post_rst_busy",      64'(busy),      64'd0);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        chk("post_rst_result",    64'(result),    64'd0);
        chk("post_rst_in_ready",  64'(in_ready),  64'd1);
        repeat (40) @(posedge clk);
        #1;
        chk("no_stale_out_valid", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
